updown_counter_chain: RTL and testbench
=======================================

UPDOWN_COUNTER_CHAIN -- requirements
Module: updown_counter_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits; legal range 1..32.
REQ-002 SHALL have parameter INIT_VALUE, default 0: value Q takes on reset; must be < 2^WIDTH.
REQ-003 SHALL have parameter MODE, default MODE_WRAP: MODE_WRAP (0) wraps at the boundary; MODE_SAT (1) saturates at the boundary.
REQ-004 SHALL have parameter DIV, default 1: prescale ratio, one count step per DIV enabled cycles; legal range 1..256.
REQ-005 SHALL have port C, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port RN, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port E, input, 1 bit: active-high count enable.
REQ-008 SHALL have port LD, input, 1 bit: active-high synchronous load.
REQ-009 SHALL have port D, input, WIDTH bits: load value.
REQ-010 SHALL have port UP, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-011 SHALL have port Q, output, WIDTH bits: registered count value.
REQ-012 SHALL have port TC, output, 1 bit: combinational terminal-count flag.
REQ-013 SHALL have port OVF, output, 1 bit: registered one-cycle boundary-crossing pulse.

Function
REQ-014 SHALL apply priority per rising edge of C: RN low, then LD high, then E high, then hold.
REQ-015 SHALL, when LD=1, set Q to D at the next edge, clear the prescaler and drive OVF=0; E and UP are ignored that cycle.
REQ-016 SHALL, when E=1 and LD=0, advance the prescaler; a step occurs when the prescaler equals DIV-1, and the prescaler then returns to 0.
REQ-017 SHALL, with DIV=1, step on every enabled cycle and implement no prescaler storage.
REQ-018 SHALL, on an up step, set Q to Q+1 mod 2^WIDTH.
REQ-019 SHALL, on a down step, set Q to Q-1 mod 2^WIDTH.
REQ-020 SHALL, on an up step from MAX (2^WIDTH-1), set Q to 0 in MODE_WRAP and hold MAX in MODE_SAT.
REQ-021 SHALL, on a down step from 0, set Q to MAX in MODE_WRAP and hold 0 in MODE_SAT.
REQ-022 SHALL drive OVF=1 for exactly the one cycle after any step taken at a boundary, in both modes; OVF SHALL be 0 otherwise.
REQ-023 SHALL drive TC = (UP ? Q==MAX : Q==0) combinationally, with zero latency.
REQ-024 SHALL, when E=0 and LD=0, hold both Q and the prescaler and drive OVF=0.
REQ-025 SHALL, on a UP change between steps, keep the prescaler value; the next step uses the new direction.
REQ-026 SHALL compute Q±1 on a per-bit propagate/carry ripple chain: increment adds 1, decrement adds all-ones.

Reset
REQ-027 SHALL, with RN=0 at a rising edge of C, set Q=INIT_VALUE, prescaler=0 and OVF=0, regardless of LD and E.
REQ-028 SHALL, when reset is applied mid-prescale, discard the partial prescale count.
REQ-029 SHALL also give Q the initial value INIT_VALUE for simulation.

Structure
REQ-030 SHALL take the MODE_WRAP/MODE_SAT constants and the WIDTH/DIV legal limits from the shared package genesis2_cnt_pkg.
REQ-031 SHALL instantiate one sub-module, carry_chain (WIDTH-bit ripple of 1-bit adder-carry cells), for the ±1 arithmetic.
REQ-032 SHALL reject illegal WIDTH, DIV or INIT_VALUE with an elaboration-time error.

Verification
REQ-033 SHALL cover up-wrap: WIDTH=4, MODE_WRAP, DIV=1, LD D=14, then E=1 UP=1 for 3 cycles -> Q 14,15,0,1; TC=1 while Q=15; OVF=1 in the cycle Q=0.
REQ-034 SHALL cover saturate: WIDTH=4, MODE_SAT, LD D=1, E=1 UP=0 for 4 cycles -> Q 1,0,0,0; OVF=1 in the cycle after each step taken at 0.
REQ-035 SHALL cover prescale: DIV=3, WIDTH=4, Q=0, E=1 UP=1 for 9 cycles -> Q=3; dropping E for 2 cycles mid-prescale does not change the step phase.
REQ-036 SHALL cover priority: RN=0 with LD=1, D=9, E=1 -> Q=INIT_VALUE; next cycle RN=1 with LD=1, E=1 -> Q=9.
REQ-037 SHALL cover reset mid-operation: DIV=4, after 2 enabled cycles pulse RN low -> Q=INIT_VALUE, and the first step needs 4 further enabled cycles.
REQ-038 SHALL cover WIDTH=1 wrap: UP=1 steps give Q 0,1,0 with OVF pulsing, and TC tracks UP.

Source files
------------

// File: rtl/genesis2_cnt_pkg.sv
// rtl/genesis2_cnt_pkg.sv - shared counter constants and legal parameter limits
package genesis2_cnt_pkg;

  // Boundary behaviour selectors
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Legal parameter ranges
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;
  localparam int DIV_MIN   = 1;
  localparam int DIV_MAX   = 256;

  // Prescaler register width; DIV=1 builds no prescaler and the value 1 is unused
  function automatic int pre_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/carry_chain.sv
// rtl/carry_chain.sv - ripple chain of 1-bit adder-carry cells computing a+1 or a-1
module carry_chain #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             dn,
  output logic [WIDTH-1:0] y,
  output logic             co
);

  // c[i] is the carry into cell i; the chain starts with no carry in
  logic [WIDTH:0] c;
  assign c[0] = 1'b0;

  // Increment adds 0..01, decrement adds all-ones; bit 0 of the addend is 1 either way
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic b_bit;
    logic p_bit;
    assign b_bit    = (i == 0) ? 1'b1 : dn;
    assign p_bit    = a[i] ^ b_bit;
    assign y[i]     = p_bit ^ c[i];
    assign c[i+1]   = (a[i] & b_bit) | (p_bit & c[i]);
  end

  // Carry out is 1 on increment from MAX, and 0 on decrement from zero
  assign co = c[WIDTH];

endmodule

// File: rtl/updown_counter_chain.sv
// rtl/updown_counter_chain.sv - prescaled up/down counter with wrap or saturate boundary
module updown_counter_chain
  import genesis2_cnt_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int unsigned INIT_VALUE = 0,
  parameter int          MODE       = MODE_WRAP,
  parameter int          DIV        = 1
) (
  input  logic             C,
  input  logic             RN,
  input  logic             E,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             OVF
);

  // Reject illegal configurations while elaborating
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("updown_counter_chain: WIDTH out of range");
  end
  if (DIV < DIV_MIN || DIV > DIV_MAX) begin : g_bad_div
    $error("updown_counter_chain: DIV out of range");
  end
  if (64'(INIT_VALUE) >= (64'd1 << WIDTH)) begin : g_bad_init
    $error("updown_counter_chain: INIT_VALUE does not fit in WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_V  = '1;
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VALUE);
  localparam int               PW     = pre_width(DIV);

  logic [WIDTH-1:0] q_q = INIT_V;
  logic [WIDTH-1:0] q_d;
  logic             ovf_q = 1'b0;
  logic             ovf_d;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             at_bound;
  logic             step;

  carry_chain #(.WIDTH(WIDTH)) u_chain (
    .a  (q_q),
    .dn (~UP),
    .y  (sum),
    .co (co)
  );

  // Boundary: increment carries out of MAX, decrement fails to carry out of zero
  assign at_bound = UP ? co : ~co;

  if (DIV == 1) begin : g_no_pre
    // Every enabled, non-load cycle is a step
    assign step = E & ~LD;
  end else begin : g_pre
    logic [PW-1:0] pre_q = '0;
    logic [PW-1:0] pre_d;
    logic          pre_last;

    assign pre_last = (pre_q == PW'(DIV - 1));
    assign step     = E & ~LD & pre_last;

    // Prescaler: cleared by load, advanced by enable, held otherwise
    always_comb begin
      pre_d = pre_q;
      if (LD) begin
        pre_d = '0;
      end else if (E) begin
        pre_d = pre_last ? '0 : pre_q + PW'(1);
      end
    end

    // Prescaler register; reset drops any partial count
    always_ff @(posedge C) begin
      if (!RN) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_d;
      end
    end
  end

  // Next count and boundary pulse; load wins over stepping
  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    if (LD) begin
      q_d = D;
    end else if (step) begin
      if (at_bound) begin
        ovf_d = 1'b1;
        q_d   = (MODE == MODE_SAT) ? q_q : sum;
      end else begin
        q_d = sum;
      end
    end
  end

  // Count and pulse registers
  always_ff @(posedge C) begin
    if (!RN) begin
      q_q   <= INIT_V;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign OVF = ovf_q;
  assign TC  = UP ? (q_q == MAX_V) : (q_q == '0);

endmodule

// File: tb/tb_updown_counter_chain.sv
// tb/tb_updown_counter_chain.sv - self-checking bench for updown_counter_chain
module tb_updown_counter_chain;

  logic       c = 1'b0;
  logic       rn, e, ld, up;
  logic [3:0] d;

  logic [3:0] q0, q1, q2, q3;
  logic [0:0] q4;
  logic [4:0] tc, ovf;

  int checks   = 0;
  int failures = 0;

  // Configuration of each instance: width, mode, div, init
  int cw[5]    = '{4, 4, 4, 4, 1};
  int cmode[5] = '{0, 1, 0, 0, 0};
  int cdiv[5]  = '{1, 1, 3, 4, 1};
  int cinit[5] = '{0, 0, 0, 5, 0};

  // Reference state
  int mq[5];
  int mp[5];
  int movf[5];

  always #5 c = ~c;

  updown_counter_chain #(.WIDTH(4), .INIT_VALUE(0), .MODE(0), .DIV(1)) u0 (
    .C(c), .RN(rn), .E(e), .LD(ld), .D(d), .UP(up), .Q(q0), .TC(tc[0]), .OVF(ovf[0]));
  updown_counter_chain #(.WIDTH(4), .INIT_VALUE(0), .MODE(1), .DIV(1)) u1 (
    .C(c), .RN(rn), .E(e), .LD(ld), .D(d), .UP(up), .Q(q1), .TC(tc[1]), .OVF(ovf[1]));
  updown_counter_chain #(.WIDTH(4), .INIT_VALUE(0), .MODE(0), .DIV(3)) u2 (
    .C(c), .RN(rn), .E(e), .LD(ld), .D(d), .UP(up), .Q(q2), .TC(tc[2]), .OVF(ovf[2]));
  updown_counter_chain #(.WIDTH(4), .INIT_VALUE(5), .MODE(0), .DIV(4)) u3 (
    .C(c), .RN(rn), .E(e), .LD(ld), .D(d), .UP(up), .Q(q3), .TC(tc[3]), .OVF(ovf[3]));
  updown_counter_chain #(.WIDTH(1), .INIT_VALUE(0), .MODE(0), .DIV(1)) u4 (
    .C(c), .RN(rn), .E(e), .LD(ld), .D(d[0:0]), .UP(up), .Q(q4), .TC(tc[4]), .OVF(ovf[4]));

  function automatic int get_q(input int i);
    case (i)
      0:       return int'(q0);
      1:       return int'(q1);
      2:       return int'(q2);
      3:       return int'(q3);
      default: return int'(q4);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Apply the inputs seen at this edge to every reference counter
  task automatic model_update();
    for (int i = 0; i < 5; i++) begin
      int mx;
      mx = (1 << cw[i]) - 1;
      if (!rn) begin
        mq[i] = cinit[i]; mp[i] = 0; movf[i] = 0;
      end else if (ld) begin
        mq[i] = int'(d) & mx; mp[i] = 0; movf[i] = 0;
      end else if (e) begin
        movf[i] = 0;
        if (mp[i] == cdiv[i] - 1) begin
          mp[i] = 0;
          if (up) begin
            if (mq[i] == mx) begin
              movf[i] = 1;
              mq[i] = (cmode[i] == 1) ? mx : 0;
            end else begin
              mq[i] = mq[i] + 1;
            end
          end else begin
            if (mq[i] == 0) begin
              movf[i] = 1;
              mq[i] = (cmode[i] == 1) ? 0 : mx;
            end else begin
              mq[i] = mq[i] - 1;
            end
          end
        end else begin
          mp[i] = mp[i] + 1;
        end
      end else begin
        movf[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 5; i++) begin
      int mx;
      int etc;
      mx  = (1 << cw[i]) - 1;
      etc = up ? int'(mq[i] == mx) : int'(mq[i] == 0);
      chk($sformatf("u%0d_q", i), get_q(i), mq[i]);
      chk($sformatf("u%0d_ovf", i), int'(ovf[i]), movf[i]);
      chk($sformatf("u%0d_tc", i), int'(tc[i]), etc);
    end
  endtask

  task automatic cycle();
    @(posedge c);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic rn_i, input logic ld_i, input logic e_i,
                       input logic up_i, input logic [3:0] d_i);
    rn = rn_i; ld = ld_i; e = e_i; up = up_i; d = d_i;
  endtask

  typedef struct {
    logic       ld;
    logic       e;
    logic       up;
    logic [3:0] d;
  } vec_t;

  vec_t vecs[8] = '{
    '{1'b1, 1'b1, 1'b0, 4'd7},
    '{1'b0, 1'b1, 1'b0, 4'd0},
    '{1'b0, 1'b1, 1'b1, 4'd3},
    '{1'b0, 1'b0, 1'b1, 4'd3},
    '{1'b0, 1'b1, 1'b1, 4'd3},
    '{1'b1, 1'b0, 1'b0, 4'd0},
    '{1'b0, 1'b1, 1'b0, 4'd0},
    '{1'b0, 1'b1, 1'b0, 4'd0}
  };

  initial begin
    for (int i = 0; i < 5; i++) begin
      mq[i] = cinit[i]; mp[i] = 0; movf[i] = 0;
    end

    // Reset beats load and enable
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
    cycle();
    chk("rst_q0", int'(q0), 0);
    chk("rst_q3", int'(q3), 5);
    chk("rst_ovf0", int'(ovf[0]), 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
    cycle();
    chk("load_beats_en_q0", int'(q0), 9);

    // Up wrap through 15
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd14);
    cycle();
    chk("wrap_load_q0", int'(q0), 14);
    chk("wrap_load_tc0", int'(tc[0]), 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    cycle();
    chk("wrap_q0_15", int'(q0), 15);
    chk("wrap_tc0_at_max", int'(tc[0]), 1);
    cycle();
    chk("wrap_q0_0", int'(q0), 0);
    chk("wrap_ovf0_pulse", int'(ovf[0]), 1);
    cycle();
    chk("wrap_q0_1", int'(q0), 1);
    chk("wrap_ovf0_clear", int'(ovf[0]), 0);

    // Down saturate at zero
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
    cycle();
    chk("sat_load_q1", int'(q1), 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    cycle();
    chk("sat_q1_0", int'(q1), 0);
    chk("sat_ovf1_none", int'(ovf[1]), 0);
    cycle();
    chk("sat_q1_hold", int'(q1), 0);
    chk("sat_ovf1_a", int'(ovf[1]), 1);
    cycle();
    chk("sat_ovf1_b", int'(ovf[1]), 1);
    chk("wrap_down_q0", int'(q0), 14);

    // Prescale by 3 with an enable gap
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int k = 0; k < 9; k++) cycle();
    chk("pre_q2_9cyc", int'(q2), 3);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    cycle();
    cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    cycle();
    chk("pre_gap_q2", int'(q2), 3);
    cycle();
    chk("pre_gap_step_q2", int'(q2), 4);

    // Reset mid-prescale on DIV=4
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    cycle();
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    cycle();
    chk("midrst_q3", int'(q3), 5);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int k = 0; k < 3; k++) cycle();
    chk("midrst_q3_nostep", int'(q3), 5);
    cycle();
    chk("midrst_q3_step", int'(q3), 6);

    // One-bit counter
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    cycle();
    chk("w1_q_1", int'(q4), 1);
    chk("w1_ovf_0", int'(ovf[4]), 0);
    cycle();
    chk("w1_q_0", int'(q4), 0);
    chk("w1_ovf_1", int'(ovf[4]), 1);
    cycle();
    chk("w1_q_1b", int'(q4), 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    #1;
    chk("w1_tc_down", int'(tc[4]), 0);
    up = 1'b1;
    #1;
    chk("w1_tc_up", int'(tc[4]), 1);
    cycle();
    chk("w1_hold_q", int'(q4), 1);
    chk("w1_hold_ovf", int'(ovf[4]), 0);

    // Mixed vectors, checked against the model each cycle
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, vecs[k].ld, vecs[k].e, vecs[k].up, vecs[k].d);
      cycle();
    end
    chk("mix_q0", int'(q0), 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
